// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M execute-stage multiply/divide unit.
// A multiply takes a single cycle from the registered operands.
// A divide uses restoring division and produces one quotient bit per cycle.
// Results leave through a registered valid/ready handshake.
// flush_i abandons any operation that is still in flight.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_addr_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  // Architectural and working state
  logic [1:0]      state_q,    state_d;
  logic [2:0]      op_q,       op_d;
  // a_q: multiplicand, or dividend magnitude that shifts into the quotient,
  //      or the precomputed special-case result.
  logic [XLEN-1:0] a_q,        a_d;
  // b_q: multiplier, or divisor magnitude.
  logic [XLEN-1:0] b_q,        b_d;
  logic [XLEN-1:0] rem_q,      rem_d;
  logic [CW-1:0]   count_q,    count_d;
  logic            neg_quo_q,  neg_quo_d;
  logic            neg_rem_q,  neg_rem_d;
  logic            special_q,  special_d;
  logic [4:0]      rd_q,       rd_d;
  logic [XLEN-1:0] result_q,   result_d;
  logic [4:0]      rd_out_q,   rd_out_d;

  logic accept;

  // Operand decode for an incoming divide
  logic            in_signed;
  logic            in_rs1_neg;
  logic            in_rs2_neg;
  logic [XLEN-1:0] in_abs1;
  logic [XLEN-1:0] in_abs2;
  logic            in_div_zero;
  logic            in_div_ovf;
  logic [XLEN-1:0] in_special_res;

  // Multiply datapath
  logic            mul_a_sign;
  logic            mul_b_sign;
  logic [2*XLEN-1:0] mul_a;
  logic [2*XLEN-1:0] mul_b;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0] mul_res;

  // Division step datapath
  logic [XLEN:0]   trial;
  logic            q_bit;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] div_res;

  // Handshake outputs
  assign ready_o   = (state_q == S_IDLE) || ((state_q == S_DONE) && ready_i);
  assign valid_o   = (state_q == S_DONE);
  assign result_o  = result_q;
  assign rd_addr_o = rd_out_q;
  assign accept    = valid_i && ready_o && !flush_i;

  // Divide operands are decoded at acceptance, so iteration only sees magnitudes
  always_comb begin
    in_signed      = ~op_i[0];
    in_rs1_neg     = in_signed & rs1_i[XLEN-1];
    in_rs2_neg     = in_signed & rs2_i[XLEN-1];
    in_abs1        = in_rs1_neg ? (~rs1_i + 1'b1) : rs1_i;
    in_abs2        = in_rs2_neg ? (~rs2_i + 1'b1) : rs2_i;
    in_div_zero    = (rs2_i == '0);
    in_div_ovf     = in_signed && (rs1_i == INT_MIN) && (rs2_i == '1);
    in_special_res = '0;
    if (in_div_zero) begin
      // A zero divisor gives all-ones for the quotient and the dividend for the remainder
      in_special_res = op_i[1] ? rs1_i : '1;
    end else begin
      // INT_MIN / -1 overflows: the quotient wraps to INT_MIN and the remainder is 0
      in_special_res = op_i[1] ? '0 : INT_MIN;
    end
  end

  // Extend the operands to 64 bits so that one multiplier covers every signedness mix
  always_comb begin
    mul_a_sign = ((op_q == OP_MULH) || (op_q == OP_MULHSU)) & a_q[XLEN-1];
    mul_b_sign = (op_q == OP_MULH) & b_q[XLEN-1];
    mul_a      = {{XLEN{mul_a_sign}}, a_q};
    mul_b      = {{XLEN{mul_b_sign}}, b_q};
    product    = mul_a * mul_b;
    mul_res    = (op_q == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
  end

  // One restoring-division step, then the sign fixup used on the final step
  always_comb begin
    trial    = {rem_q, a_q[XLEN-1]} - {1'b0, b_q};
    q_bit    = ~trial[XLEN];
    rem_next = q_bit ? trial[XLEN-1:0] : {rem_q[XLEN-2:0], a_q[XLEN-1]};
    quo_next = {a_q[XLEN-2:0], q_bit};
    quo_fix  = neg_quo_q ? (~quo_next + 1'b1) : quo_next;
    rem_fix  = neg_rem_q ? (~rem_next + 1'b1) : rem_next;
    div_res  = op_q[1] ? rem_fix : quo_fix;
  end

  // Next-state logic: FSM progress first, then acceptance, then flush overrides
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    rem_d     = rem_q;
    count_d   = count_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    special_d = special_q;
    rd_d      = rd_q;
    result_d  = result_q;
    rd_out_d  = rd_out_q;

    case (state_q)
      S_MUL: begin
        result_d = mul_res;
        rd_out_d = rd_q;
        state_d  = S_DONE;
      end
      S_DIV: begin
        if (special_q) begin
          // The special result was resolved at acceptance; publish it without iterating
          result_d = a_q;
          rd_out_d = rd_q;
          state_d  = S_DONE;
        end else begin
          a_d     = quo_next;
          rem_d   = rem_next;
          count_d = count_q + CW'(1);
          if (count_q == LAST_STEP) begin
            result_d = div_res;
            rd_out_d = rd_q;
            count_d  = '0;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        // The result holds until downstream takes it
        if (ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase

    // Acceptance can come from IDLE, or from DONE in the same cycle as the transfer
    if (accept) begin
      op_d    = op_i;
      rd_d    = rd_addr_i;
      rem_d   = '0;
      count_d = '0;
      if (!op_i[2]) begin
        a_d       = rs1_i;
        b_d       = rs2_i;
        special_d = 1'b0;
        neg_quo_d = 1'b0;
        neg_rem_d = 1'b0;
        state_d   = S_MUL;
      end else begin
        special_d = in_div_zero | in_div_ovf;
        a_d       = (in_div_zero | in_div_ovf) ? in_special_res : in_abs1;
        b_d       = in_abs2;
        neg_quo_d = in_rs1_neg ^ in_rs2_neg;
        neg_rem_d = in_rs1_neg;
        state_d   = S_DIV;
      end
    end

    // A flush drops any partial work; a transfer already on the outputs still completes
    if (flush_i) begin
      state_d = S_IDLE;
      count_d = '0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      count_q   <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      special_q <= 1'b0;
      rd_q      <= '0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      count_q   <= count_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      special_q <= special_d;
      rd_q      <= rd_d;
      result_q  <= result_d;
      rd_out_q  <= rd_out_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: checks muldiv_unit against an arithmetic reference model,
// using directed corner cases plus randomized operations.
module tb_muldiv_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic [4:0]  rd_addr_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  muldiv_unit #(.XLEN(32)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (flush_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .op_i      (op_i),
    .rs1_i     (rs1_i),
    .rs2_i     (rs2_i),
    .rd_addr_i (rd_addr_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .result_o  (result_o),
    .rd_addr_o (rd_addr_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: RV32M semantics computed with plain 64-bit arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int          ia;
    int          ib;
    longint      sa;
    longint      sb;
    longint      ub;
    logic [63:0] p;
    ia = a;
    ib = b;
    sa = ia;
    sb = ib;
    ub = longint'({32'd0, b});
    p  = '0;
    case (op)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      default: begin
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
          3'd4:    return 32'(ia / ib);
          3'd5:    return a / b;
          3'd6:    return 32'(ia % ib);
          default: return a % b;
        endcase
      end
    endcase
  endfunction

  // Cycles from acceptance to valid_o: one for multiplies and special divides, else XLEN
  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (!op[2]) return 1;
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 32;
  endfunction

  // Present one operation and return just after its acceptance edge
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk_i);
    op_i      = op;
    rs1_i     = a;
    rs2_i     = b;
    rd_addr_i = rd;
    valid_i   = 1'b1;
    #1;
    check("accept_ready", 64'(ready_o), 64'd1);
    @(posedge clk_i);
  endtask

  // Wait (bounded) for valid_o, then check latency, result, rd and busy-time ready_o
  task automatic collect(input string tag, input logic [31:0] exp, input logic [4:0] rd,
                         input int exp_lat);
    int lat;
    bit rdy_seen;
    lat      = 0;
    rdy_seen = 1'b0;
    @(negedge clk_i);
    valid_i = 1'b0;
    ready_i = 1'b0;
    while (!valid_o && lat < 200) begin
      if (ready_o) rdy_seen = 1'b1;
      @(negedge clk_i);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, 64'(result_o), 64'(exp));
    check({tag, "_rd"}, 64'(rd_addr_o), 64'(rd));
    check({tag, "_busy_ready"}, 64'(rdy_seen), 64'd0);
    $display("txn %s: result=0x%08h rd=%0d latency=%0d", tag, result_o, rd_addr_o, lat);
  endtask

  // Let downstream take the result, then expect an idle unit
  task automatic release_result();
    ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    ready_i = 1'b0;
    check("release_valid", 64'(valid_o), 64'd0);
    check("release_ready", 64'(ready_o), 64'd1);
  endtask

  logic [2:0]  d_op  [12] = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7,
                              3'd4, 3'd7, 3'd4, 3'd6};
  logic [31:0] d_a   [12] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                              32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] d_b   [12] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'd2, 32'd2, 32'd7, 32'd7,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] d_exp [12] = '{32'h4000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
                              32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                              32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
  int          d_lat [12] = '{1, 1, 1, 1, 32, 32, 32, 32, 1, 1, 1, 1};

  initial begin
    bit          seen;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [4:0]  r_rd;
    int          sel;

    rst_i     = 1'b1;
    flush_i   = 1'b0;
    valid_i   = 1'b0;
    ready_i   = 1'b0;
    op_i      = '0;
    rs1_i     = '0;
    rs2_i     = '0;
    rd_addr_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    check("reset_valid", 64'(valid_o), 64'd0);
    check("reset_result", 64'(result_o), 64'd0);
    check("reset_rd", 64'(rd_addr_o), 64'd0);
    check("reset_ready", 64'(ready_o), 64'd1);

    // Directed corner cases
    for (int i = 0; i < 12; i++) begin
      issue(d_op[i], d_a[i], d_b[i], 5'(i + 1));
      collect($sformatf("directed%0d_op%0d", i, d_op[i]), d_exp[i], 5'(i + 1), d_lat[i]);
      release_result();
    end

    // Backpressure for 10 cycles, then a back-to-back accept during the transfer
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20);
    collect("bp_mulhu", 32'hFFFF_FFFE, 5'd20, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check("bp_result", 64'(result_o), 64'h0000_0000_FFFF_FFFE);
      check("bp_rd", 64'(rd_addr_o), 64'd20);
      check("bp_ready", 64'(ready_o), 64'd0);
      check("bp_valid", 64'(valid_o), 64'd1);
    end
    ready_i   = 1'b1;
    valid_i   = 1'b1;
    op_i      = 3'd0;
    rs1_i     = 32'd3;
    rs2_i     = 32'd5;
    rd_addr_i = 5'd21;
    #1;
    check("b2b_ready", 64'(ready_o), 64'd1);
    @(posedge clk_i);
    collect("b2b_mul", 32'd15, 5'd21, 1);
    release_result();

    // Flush at division step 15: that op must never produce a result
    issue(3'd5, 32'd1000, 32'd3, 5'd11);
    repeat (15) @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    flush_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    flush_i = 1'b0;
    check("flush_valid", 64'(valid_o), 64'd0);
    check("flush_ready", 64'(ready_o), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk_i);
      if (valid_o) seen = 1'b1;
    end
    check("flush_no_result", 64'(seen), 64'd0);
    issue(3'd0, 32'd7, 32'd6, 5'd12);
    collect("after_flush_mul", 32'd42, 5'd12, 1);
    release_result();

    // Flush coinciding with valid_i in IDLE drops the op
    @(negedge clk_i);
    op_i      = 3'd0;
    rs1_i     = 32'd2;
    rs2_i     = 32'd2;
    rd_addr_i = 5'd14;
    valid_i   = 1'b1;
    flush_i   = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    flush_i = 1'b0;
    seen    = 1'b0;
    repeat (5) begin
      if (valid_o) seen = 1'b1;
      @(negedge clk_i);
    end
    check("flush_accept_dropped", 64'(seen), 64'd0);
    check("flush_accept_ready", 64'(ready_o), 64'd1);

    // Reset in the middle of a divide clears every output
    issue(3'd4, 32'd1234, 32'd5, 5'd13);
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    rst_i   = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    check("midrst_valid", 64'(valid_o), 64'd0);
    check("midrst_result", 64'(result_o), 64'd0);
    check("midrst_rd", 64'(rd_addr_o), 64'd0);
    check("midrst_ready", 64'(ready_o), 64'd1);

    // Randomized operations against the reference model
    for (int i = 0; i < 80; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = $urandom;
      r_rd = 5'($urandom_range(0, 31));
      sel  = int'($urandom_range(0, 9));
      if (sel == 0) begin
        r_b = 32'd0;
      end else if (sel == 1) begin
        r_a = 32'h8000_0000;
        r_b = 32'hFFFF_FFFF;
      end else if (sel == 2) begin
        r_a = $urandom_range(0, 1000);
        r_b = $urandom_range(1, 20);
      end else if (sel == 3) begin
        r_b = -($urandom_range(1, 20));
      end
      issue(r_op, r_a, r_b, r_rd);
      collect($sformatf("rand%0d_op%0d_a%08h_b%08h", i, r_op, r_a, r_b),
              ref_result(r_op, r_a, r_b), r_rd, ref_latency(r_op, r_a, r_b));
      release_result();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
